// File: rtl/hsi_s_rx_frame_buf_pkg.sv
// Shared definitions for the slave RX frame buffer: error/flag layout, descriptor widths, read FSM states.
package hsi_s_rx_frame_buf_pkg;

  localparam int FLAG_W = 8;
  localparam int ERR_W  = 6;

  // rx_errs bit positions as produced by RX control
  localparam int ERR_PAR  = 0;
  localparam int ERR_STOP = 1;
  localparam int ERR_CRC  = 2;
  localparam int ERR_LEN  = 3;
  localparam int ERR_SYNC = 4;
  localparam int ERR_CODE = 5;

  // rx_flag layout: low nibble message type, high nibble channel
  localparam int FLAG_TYPE_LSB = 0;
  localparam int FLAG_TYPE_W   = 4;
  localparam int FLAG_CH_LSB   = 4;
  localparam int FLAG_CH_W     = 4;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_LOAD   = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/hsi_s_rx_frame_buf_desc_fifo.sv
// hsi_desc_fifo: synchronous show-ahead FIFO of committed frame descriptors {len, flag}.
module hsi_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end

  assign count = wp - rp;
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

endmodule

// File: rtl/hsi_s_rx_frame_buf.sv
// Slave RX frame buffer: speculative byte store, commit/rollback at frame end, valid/ready frame stream out.
// Optional statistics counters are enabled with HSI_RX_FRAME_BUF_STATS_EN.
module hsi_s_rx_frame_buf
  import hsi_s_rx_frame_buf_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int MAX_LEN    = 32,
  parameter int DESC_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  d,
  input  logic                        d_rdy,
  input  logic                        frame_end,
  input  logic [FLAG_W-1:0]           rx_flag,
  input  logic [ERR_W-1:0]            rx_errs,
  output logic [7:0]                  m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic [FLAG_W-1:0]           m_flag,
  output logic [$clog2(DESC_DEPTH):0] frames_pend,
  output logic                        drop
`ifdef HSI_RX_FRAME_BUF_STATS_EN
  ,
  output logic [15:0]                 ok_cnt,
  output logic [7:0]                  err_drop_cnt,
  output logic [7:0]                  ovf_drop_cnt
`endif
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int LEN_W = len_w(MAX_LEN);
  localparam int DW    = LEN_W + FLAG_W;
  localparam int CW    = $clog2(DESC_DEPTH) + 1;

  logic [7:0]       mem [DEPTH];
  logic [7:0]       ram_q;
  logic [PW-1:0]    wr_ptr, cm_ptr, rd_ptr, used, wr_nxt, rd_p1, rd_p2;
  logic [LEN_W-1:0] cur_len, len_nxt, rem_len;
  logic             ovf, ovf_nxt, accept, commit, buf_full, at_max;

  logic             fifo_full, fifo_empty, pop;
  logic [DW-1:0]    desc;
  logic [CW-1:0]    fifo_cnt;

  rd_state_t        state, nstate;
  logic [AW-1:0]    raddr;
  logic             fire;

  // ---------------- write side ----------------
  assign used     = wr_ptr - rd_ptr;
  assign buf_full = used[AW];           // used never exceeds DEPTH
  assign at_max   = (cur_len == LEN_W'(MAX_LEN));
  assign accept   = d_rdy && !buf_full && !at_max;
  assign ovf_nxt  = ovf | (d_rdy & ~accept);
  assign len_nxt  = cur_len + LEN_W'(accept);
  assign wr_nxt   = wr_ptr + PW'(accept);
  // A byte arriving with frame_end belongs to the ending frame, hence the *_nxt terms
  assign commit   = frame_end && (rx_errs == '0) && !ovf_nxt &&
                    (len_nxt != '0) && !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      cm_ptr  <= '0;
      cur_len <= '0;
      ovf     <= 1'b0;
      drop    <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (frame_end) begin
        cur_len <= '0;
        ovf     <= 1'b0;
        if (commit) begin
          wr_ptr <= wr_nxt;
          cm_ptr <= wr_nxt;
        end else begin
          wr_ptr <= cm_ptr;
          drop   <= 1'b1;
        end
      end else begin
        wr_ptr  <= wr_nxt;
        cur_len <= len_nxt;
        ovf     <= ovf_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= d;
    ram_q <= mem[raddr];
  end

  hsi_desc_fifo #(.DEPTH(DESC_DEPTH), .W(DW)) u_desc (
    .clk   (clk),
    .rst   (rst),
    .push  (commit),
    .din   ({len_nxt, rx_flag}),
    .pop   (pop),
    .dout  (desc),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // ---------------- read side ----------------
  assign fire  = m_valid && m_ready;
  assign rd_p1 = rd_ptr + PW'(1);
  assign rd_p2 = rd_ptr + PW'(2);

  // RAM address always runs one byte ahead of m_data so a stream sustains one byte per cycle
  always_comb begin
    nstate = state;
    pop    = 1'b0;
    raddr  = rd_ptr[AW-1:0];
    unique case (state)
      RD_IDLE: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          nstate = RD_LOAD;
        end
      end
      RD_LOAD: begin
        raddr  = rd_p1[AW-1:0];
        nstate = RD_STREAM;
      end
      RD_STREAM: begin
        raddr = fire ? rd_p2[AW-1:0] : rd_p1[AW-1:0];
        if (fire && m_last) nstate = RD_IDLE;
      end
      default: nstate = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RD_IDLE;
      rd_ptr  <= '0;
      rem_len <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_flag  <= '0;
    end else begin
      state <= nstate;
      unique case (state)
        RD_IDLE: begin
          if (pop) begin
            rem_len <= desc[DW-1:FLAG_W];
            m_flag  <= desc[FLAG_W-1:0];
          end
        end
        RD_LOAD: begin
          m_data  <= ram_q;
          m_valid <= 1'b1;
          m_last  <= (rem_len == LEN_W'(1));
        end
        RD_STREAM: begin
          if (fire) begin
            rd_ptr  <= rd_p1;
            rem_len <= rem_len - LEN_W'(1);
            if (m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end else begin
              m_data <= ram_q;
              m_last <= (rem_len == LEN_W'(2));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign frames_pend = fifo_cnt + CW'(state != RD_IDLE);

`ifdef HSI_RX_FRAME_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_cnt       <= '0;
      err_drop_cnt <= '0;
      ovf_drop_cnt <= '0;
    end else if (frame_end) begin
      if (commit)
        ok_cnt <= ok_cnt + 16'd1;
      else if (rx_errs != '0) begin
        if (err_drop_cnt != 8'hFF) err_drop_cnt <= err_drop_cnt + 8'd1;
      end else if (ovf_drop_cnt != 8'hFF)
        ovf_drop_cnt <= ovf_drop_cnt + 8'd1;
    end
  end
`endif

endmodule
